lfsr_traffic_ctrl: RTL and testbench
====================================

Name: lfsr_traffic_ctrl

Overview:
Self-checking DDR3 traffic sequencer for emulation. On start it writes NUM_BURSTS bursts of LFSR pseudo-random data to consecutive addresses. It then reseeds the same LFSR and reads the bursts back, comparing every beat. One pattern generator is shared between the write phase and the read-check phase. The block sits between the emulation host registers and the controller's command/data ports.

Parameters:
ADDR_WIDTH, 24, width of cmd_addr (beat-granular address)
DATA_WIDTH, 64, data beat width; must be >= 20
BURST_LEN, 8, beats per command; power of two, 2..16
NUM_BURSTS, 16, bursts per phase; >= 1
SEED, 0, LFSR load value at the start of each phase
TIMEOUT_CYCLES, 1024, read-beat watchdog limit (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begins a run when idle or done
busy  out  1  high from the cycle after start through the last read beat
done  out  1  high after run completion; held until the next accepted start
pass  out  1  done && err_count==0 && !timeout
err_count  out  16  number of mismatched beats, saturating at 16'hFFFF
timeout  out  1  read watchdog fired; constant 0 without the macro
cmd_valid  out  1  command request
cmd_ready  in  1  controller accepts the command
cmd_write  out  1  1 = write, 0 = read
cmd_addr  out  ADDR_WIDTH  burst_idx*BURST_LEN
wr_valid  out  1  write beat valid
wr_ready  in  1  write beat accepted
wr_data  out  DATA_WIDTH  current LFSR value
rd_valid  in  1  read beat valid; no backpressure, in order
rd_data  in  DATA_WIDTH  read beat

Behaviour:
- Reset (async, active-high): FSM goes to IDLE. All outputs are 0, and LFSR, burst_idx, beat_cnt and err_count are 0.
- LFSR: loads SEED. On each advance it does state <= {state[DATA_WIDTH-2:0], fb}, where fb = ~(s[19]^s[6]^s[2]^s[1]). It advances only on an accepted write beat (wr_valid&&wr_ready) or a received read beat (rd_valid in RD_DATA).
- FSM states: IDLE, WR_CMD, WR_DATA, RD_SEED, RD_CMD, RD_DATA, DONE.
- IDLE/DONE, start: clear err_count, done, timeout and burst_idx; load SEED; go to WR_CMD. start is ignored in every other state.
- WR_CMD: cmd_valid=1, cmd_write=1. On cmd_ready, go to WR_DATA with beat_cnt=0.
- WR_DATA: wr_valid=1 and wr_data=LFSR. Each handshake advances the LFSR and beat_cnt. After beat BURST_LEN-1, if burst_idx==NUM_BURSTS-1 go to RD_SEED; otherwise burst_idx++ and go to WR_CMD.
- RD_SEED: one cycle; load SEED and set burst_idx=0; go to RD_CMD.
- RD_CMD: cmd_valid=1, cmd_write=0. On cmd_ready, go to RD_DATA.
- RD_DATA: each rd_valid compares rd_data to LFSR; on mismatch, err_count++ (saturating). The LFSR advances every beat. Burst and phase completion work as in the write phase; after the final beat, go to DONE.
- rd_valid outside RD_DATA is ignored and counts nothing.
- cmd_valid and wr_valid hold stable until their handshake completes.
- cmd_addr is registered and valid whenever cmd_valid=1.
- Command issue latency: cmd_valid asserts the cycle after start.
- DONE: done=1 and busy=0. pass is combinational from the registered flags.
- Reset asserted mid-run aborts immediately; there is no drain of in-flight beats.

Optional Feature:
Macro TRAFFIC_TIMEOUT_EN.
- Defined: a watchdog counter clears on entry to RD_DATA and on each rd_valid, and increments otherwise. When it reaches TIMEOUT_CYCLES the block sets timeout=1 and goes to DONE; pass=0.
- Undefined: no counter exists, timeout is tied to 0, and RD_DATA waits indefinitely.

Decomposition:
- Package lfsr_traffic_pkg holds:
  - state enum typedef
  - feedback tap constants 19, 6, 2, 1
  - ERR_CNT_W=16
- One sub-module, lfsr_pattern_gen: ports clk, reset, load, seed, advance, value. Load has priority over advance.

Test Plan:
- NUM_BURSTS=2, BURST_LEN=8, ready/loopback memory always ready, start -> 2 write then 2 read cmds at addresses 0 and 8; done=1, pass=1, err_count=0; wr_data beat0 = SEED=0, beat1 = 1.
- Memory model corrupts read beat 3 of burst 1 (bit 0 flipped) -> err_count=1, pass=0, done=1.
- Random cmd_ready/wr_ready stalls (50%) -> cmd_valid, cmd_addr and wr_data held stable during stalls; identical data sequence; pass=1.
- reset asserted during WR_DATA beat 4 -> all outputs 0 asynchronously; a subsequent start runs a full pass with cmd_addr restarting at 0.
- start pulsed while busy -> ignored, no restart. start pulsed in DONE -> err_count and done cleared, new run begins.
- TRAFFIC_TIMEOUT_EN, TIMEOUT_CYCLES=16, memory drops all read beats -> timeout=1 and done=1 after 16 idle cycles in RD_DATA; pass=0.

Source files
------------

// File: rtl/lfsr_traffic_pkg.sv
// Shared types and constants for the LFSR DDR3 traffic sequencer.
package lfsr_traffic_pkg;

    localparam int unsigned ERR_CNT_W = 16;

    // Feedback taps of the pattern LFSR (XNOR form, so an all-zero seed still runs)
    localparam int unsigned TAP_A = 19;
    localparam int unsigned TAP_B = 6;
    localparam int unsigned TAP_C = 2;
    localparam int unsigned TAP_D = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CMD,
        ST_WR_DATA,
        ST_RD_SEED,
        ST_RD_CMD,
        ST_RD_DATA,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lfsr_traffic_ctrl_pattern_gen.sv
// Pattern LFSR shared by the write and read-check phases; load wins over advance.
module lfsr_pattern_gen
    import lfsr_traffic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] value
);

    logic fb;

    always_comb begin
        fb = ~(value[TAP_A] ^ value[TAP_B] ^ value[TAP_C] ^ value[TAP_D]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= seed;
        end else if (advance) begin
            value <= {value[DATA_WIDTH-2:0], fb};
        end
    end

endmodule

// File: rtl/lfsr_traffic_ctrl.sv
// Self-checking DDR3 traffic sequencer: writes LFSR bursts, reseeds, reads back and compares.
// Optional read watchdog enabled by defining TRAFFIC_TIMEOUT_EN.
module lfsr_traffic_ctrl
    import lfsr_traffic_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH     = 24,
    parameter int unsigned            DATA_WIDTH     = 64,
    parameter int unsigned            BURST_LEN      = 8,
    parameter int unsigned            NUM_BURSTS     = 16,
    parameter logic [DATA_WIDTH-1:0]  SEED           = '0,
    parameter int unsigned            TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic                  timeout,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_write,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    localparam int unsigned BIDX_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

    if (DATA_WIDTH < 20 || BURST_LEN < 2 || BURST_LEN > 16 || NUM_BURSTS < 1
        || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("lfsr_traffic_ctrl: illegal parameter combination");
    end

    state_t              state;
    logic [BIDX_W-1:0]   burst_idx;
    logic [BIDX_W-1:0]   next_idx;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                last_beat;
    logic                last_burst;
    logic                lfsr_load;
    logic                lfsr_adv;
    logic                wdog_fire;

    function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [BIDX_W-1:0] idx);
        return ADDR_WIDTH'(idx) * ADDR_WIDTH'(BURST_LEN);
    endfunction

    lfsr_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pattern (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .seed    (SEED),
        .advance (lfsr_adv),
        .value   (wr_data)
    );

    always_comb begin
        last_beat  = (beat_cnt == BEAT_W'(BURST_LEN - 1));
        last_burst = (burst_idx == BIDX_W'(NUM_BURSTS - 1));
        next_idx   = burst_idx + BIDX_W'(1);
        pass       = done && (err_count == '0) && !timeout;
    end

    // Reseed at the start of each phase; step on every accepted or received beat
    always_comb begin
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: lfsr_load = start;
            ST_RD_SEED:       lfsr_load = 1'b1;
            ST_WR_DATA:       lfsr_adv  = wr_valid && wr_ready;
            ST_RD_DATA:       lfsr_adv  = rd_valid;
            default:          ;
        endcase
    end

`ifdef TRAFFIC_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] wdog;

    always_comb begin
        wdog_fire = (state == ST_RD_DATA) && !rd_valid
                    && (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
    end

    // Counts consecutive idle cycles while waiting for read beats
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog <= '0;
        end else if (state != ST_RD_DATA || rd_valid) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + WDOG_W'(1);
        end
    end
`else
    always_comb begin
        wdog_fire = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            burst_idx <= '0;
            beat_cnt  <= '0;
            err_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            wr_valid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_WR_CMD;
                        err_count <= '0;
                        done      <= 1'b0;
                        timeout   <= 1'b0;
                        busy      <= 1'b1;
                        burst_idx <= '0;
                        cmd_addr  <= '0;
                        cmd_valid <= 1'b1;
                        cmd_write <= 1'b1;
                    end
                end
                ST_WR_CMD: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        wr_valid  <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (wr_ready) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (last_beat) begin
                            wr_valid <= 1'b0;
                            if (last_burst) begin
                                state <= ST_RD_SEED;
                            end else begin
                                burst_idx <= next_idx;
                                cmd_addr  <= burst_addr(next_idx);
                                cmd_valid <= 1'b1;
                                cmd_write <= 1'b1;
                                state     <= ST_WR_CMD;
                            end
                        end
                    end
                end
                ST_RD_SEED: begin
                    burst_idx <= '0;
                    cmd_addr  <= '0;
                    cmd_valid <= 1'b1;
                    cmd_write <= 1'b0;
                    state     <= ST_RD_CMD;
                end
                ST_RD_CMD: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rd_valid) begin
                        if (rd_data != wr_data && err_count != '1) begin
                            err_count <= err_count + ERR_CNT_W'(1);
                        end
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (last_beat) begin
                            if (last_burst) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                burst_idx <= next_idx;
                                cmd_addr  <= burst_addr(next_idx);
                                cmd_valid <= 1'b1;
                                cmd_write <= 1'b0;
                                state     <= ST_RD_CMD;
                            end
                        end
                    end else if (wdog_fire) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_traffic_ctrl.sv
// Directed bench for lfsr_traffic_ctrl with a loopback memory model (2 bursts of 8 beats).
module tb_lfsr_traffic_ctrl;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 64;
    localparam int unsigned BL = 8;
    localparam int unsigned NB = 2;
    localparam int unsigned TO = 16;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          start     = 1'b0;
    logic          cmd_ready = 1'b0;
    logic          wr_ready  = 1'b0;
    logic          rd_valid  = 1'b0;
    logic [DW-1:0] rd_data   = '0;
    logic          busy, done, pass, timeout, cmd_valid, cmd_write, wr_valid;
    logic [15:0]   err_count;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    lfsr_traffic_ctrl #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .BURST_LEN      (BL),
        .NUM_BURSTS     (NB),
        .SEED           ('0),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .timeout   (timeout),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
    );

    int checks   = 0;
    int failures = 0;

    bit stall_en    = 1'b0;
    bit corrupt_en  = 1'b0;
    bit drop_rd     = 1'b0;
    bit stray_rd    = 1'b0;
    int stable_errs = 0;

    logic [DW-1:0] mem [0:NB*BL-1];
    logic [DW-1:0] rdq [$];
    logic [DW-1:0] wr_log [$];
    logic [AW:0]   cmd_log [$];
    logic [AW-1:0] cur_addr = '0;
    int            wbeat = 0;
    logic          prev_cmd_stall = 1'b0;
    logic          prev_wr_stall  = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    logic [DW-1:0] prev_wdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] s);
        return {s[DW-2:0], ~(s[19] ^ s[6] ^ s[2] ^ s[1])};
    endfunction

    // Memory side: log handshakes at the clock edge, check stall stability
    always @(posedge clk) begin
        if (reset) begin
            rdq.delete();
            prev_cmd_stall = 1'b0;
            prev_wr_stall  = 1'b0;
        end else begin
            if (prev_cmd_stall && (cmd_valid !== 1'b1 || cmd_addr !== prev_addr)) stable_errs++;
            if (prev_wr_stall && (wr_valid !== 1'b1 || wr_data !== prev_wdata)) stable_errs++;
            prev_cmd_stall = cmd_valid && !cmd_ready;
            prev_addr      = cmd_addr;
            prev_wr_stall  = wr_valid && !wr_ready;
            prev_wdata     = wr_data;
            if (cmd_valid && cmd_ready) begin
                cmd_log.push_back({cmd_write, cmd_addr});
                cur_addr = cmd_addr;
                wbeat    = 0;
                if (!cmd_write) begin
                    for (int i = 0; i < int'(BL); i++) begin
                        logic [DW-1:0] d;
                        d = mem[int'(cmd_addr) + i];
                        if (corrupt_en && cmd_addr == AW'(BL) && i == 3) d[0] = ~d[0];
                        rdq.push_back(d);
                    end
                end
            end
            if (wr_valid && wr_ready) begin
                mem[int'(cur_addr) + wbeat] = wr_data;
                wr_log.push_back(wr_data);
                wbeat++;
            end
            if (rd_valid && !stray_rd && rdq.size() > 0) void'(rdq.pop_front());
        end
    end

    always @(negedge clk) begin
        cmd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        wr_ready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stray_rd) begin
            rd_valid = 1'b1;
            rd_data  = '1;
        end else if (!drop_rd && rdq.size() > 0) begin
            rd_valid = 1'b1;
            rd_data  = rdq[0];
        end else begin
            rd_valid = 1'b0;
            rd_data  = '0;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
    endtask

    task automatic clear_logs();
        wr_log.delete();
        cmd_log.delete();
    endtask

    task automatic check_cmds(input string tag);
        chk({tag, "_ncmd"}, 64'(cmd_log.size()), 64'(4));
        chk({tag, "_cmd0"}, 64'(cmd_log[0]), 64'({1'b1, 24'd0}));
        chk({tag, "_cmd1"}, 64'(cmd_log[1]), 64'({1'b1, 24'd8}));
        chk({tag, "_cmd2"}, 64'(cmd_log[2]), 64'({1'b0, 24'd0}));
        chk({tag, "_cmd3"}, 64'(cmd_log[3]), 64'({1'b0, 24'd8}));
    endtask

    task automatic check_wdata(input string tag);
        logic [DW-1:0] m;
        int bad;
        m   = '0;
        bad = 0;
        for (int i = 0; i < int'(NB * BL); i++) begin
            if (wr_log[i] !== m) bad++;
            m = lfsr_next(m);
        end
        chk({tag, "_nbeats"}, 64'(wr_log.size()), 64'(NB * BL));
        chk({tag, "_wdata_seq_bad"}, 64'(bad), 64'(0));
    endtask

    initial begin
        int n;

        repeat (3) @(negedge clk);
        chk("rst_flags", 64'({busy, done, pass, timeout, cmd_valid, cmd_write, wr_valid}), 64'(0));
        chk("rst_err", 64'(err_count), 64'(0));
        chk("rst_wdata", 64'(wr_data), 64'(0));
        chk("rst_addr", 64'(cmd_addr), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Clean run, always ready
        clear_logs();
        pulse_start();
        chk("r1_first_cmd", 64'({cmd_valid, cmd_write, busy}), 64'(3'b111));
        chk("r1_first_addr", 64'(cmd_addr), 64'(0));
        wait_done("r1", 500);
        chk("r1_err", 64'(err_count), 64'(0));
        chk("r1_pass_busy", 64'({pass, busy}), 64'(2'b10));
        check_cmds("r1");
        chk("r1_wd0", 64'(wr_log[0]), 64'(0));
        chk("r1_wd1", 64'(wr_log[1]), 64'(1));
        chk("r1_wd2", 64'(wr_log[2]), 64'(3));
        chk("r1_wd3", 64'(wr_log[3]), 64'(6));
        chk("r1_wd4", 64'(wr_log[4]), 64'('h0d));
        chk("r1_wd5", 64'(wr_log[5]), 64'('h1a));
        check_wdata("r1");

        // One corrupted read beat (burst 1, beat 3)
        clear_logs();
        corrupt_en = 1'b1;
        pulse_start();
        chk("r2_done_cleared", 64'({done, busy}), 64'(2'b01));
        wait_done("r2", 500);
        chk("r2_err", 64'(err_count), 64'(1));
        chk("r2_pass", 64'(pass), 64'(0));
        corrupt_en = 1'b0;

        // Restart from DONE with random stalls; a start while busy must be ignored
        clear_logs();
        stall_en = 1'b1;
        pulse_start();
        chk("r3_err_cleared", 64'(err_count), 64'(0));
        chk("r3_done_cleared", 64'(done), 64'(0));
        repeat (10) @(negedge clk);
        pulse_start();
        chk("r3_busy_after_restart_try", 64'(busy), 64'(1));
        wait_done("r3", 3000);
        stall_en = 1'b0;
        chk("r3_err", 64'(err_count), 64'(0));
        chk("r3_pass", 64'(pass), 64'(1));
        chk("r3_stable", 64'(stable_errs), 64'(0));
        check_cmds("r3");
        check_wdata("r3");

        // Read beats outside RD_DATA count nothing
        stray_rd = 1'b1;
        repeat (4) @(negedge clk);
        stray_rd = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_err", 64'(err_count), 64'(0));
        chk("stray_pass", 64'({done, pass}), 64'(2'b11));

        // Async reset in burst 1 write beat 4
        clear_logs();
        pulse_start();
        n = 0;
        while (wr_log.size() != 12 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached_beat", 64'(wr_log.size()), 64'(12));
        chk("mid_addr_before", 64'(cmd_addr), 64'(8));
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_flags", 64'({busy, done, pass, timeout, cmd_valid, cmd_write, wr_valid}), 64'(0));
        chk("mid_rst_wdata", 64'(wr_data), 64'(0));
        chk("mid_rst_addr", 64'(cmd_addr), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_logs();
        pulse_start();
        wait_done("r4", 500);
        chk("r4_pass", 64'(pass), 64'(1));
        check_cmds("r4");
        chk("r4_wd1", 64'(wr_log[1]), 64'(1));

`ifdef TRAFFIC_TIMEOUT_EN
        // Memory drops every read beat: watchdog ends the run
        clear_logs();
        drop_rd = 1'b1;
        pulse_start();
        wait_done("to", 500);
        chk("to_timeout", 64'(timeout), 64'(1));
        chk("to_pass_busy", 64'({pass, busy}), 64'(0));
        drop_rd = 1'b0;
        pulse_start();
        chk("to_cleared", 64'(timeout), 64'(0));
        wait_done("to_rerun", 500);
        chk("to_rerun_pass", 64'(pass), 64'(1));
`else
        // Without the watchdog a silent memory leaves the block waiting
        clear_logs();
        drop_rd = 1'b1;
        pulse_start();
        repeat (200) @(negedge clk);
        chk("nowd_waiting", 64'({busy, done, timeout}), 64'(3'b100));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drop_rd = 1'b0;
        @(negedge clk);
        chk("nowd_after_reset", 64'({busy, done}), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
